// File: rtl/verificacion_pin_if.sv
// Keypad/card bundle between the cashier front end and the PIN verification stage.
// The master drives the card and keypad side; the slave returns the verdict.
interface verificacion_pin_if #(
  parameter int unsigned N_DIGITOS = 4
);
  logic                   tarjeta_recibida;
  logic [4*N_DIGITOS-1:0] pin_correcto;
  logic [3:0]             digito;
  logic                   digito_stb;
  logic                   pin_valido;
  logic                   advertencia;
  logic                   bloqueo;
  logic [1:0]             intentos;

  modport master (
    output tarjeta_recibida, pin_correcto, digito, digito_stb,
    input  pin_valido, advertencia, bloqueo, intentos
  );

  modport slave (
    input  tarjeta_recibida, pin_correcto, digito, digito_stb,
    output pin_valido, advertencia, bloqueo, intentos
  );
endinterface

// File: rtl/verificacion_pin.sv
// PIN entry and verification: collects BCD keypad digits while a card is present,
// compares them with the card PIN, and blocks the card after repeated failures.
module verificacion_pin #(
  parameter int unsigned N_DIGITOS    = 4,
  parameter int unsigned MAX_INTENTOS = 3
) (
  input  logic              clk,
  input  logic              reset,
  verificacion_pin_if.slave bus
);

  localparam int unsigned PIN_W = 4 * N_DIGITOS;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RECIBIENDO = 2'd1,
    COMPARA    = 2'd2,
    BLOQUEADO  = 2'd3
  } state_t;

  state_t             r_state, w_state_nx;
  logic [PIN_W-1:0]   r_pin, w_pin_nx;
  logic [PIN_W-1:0]   r_entry, w_entry_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [1:0]         r_intentos, w_intentos_nx;
  logic               r_pv, w_pv_nx;
  logic               r_adv, w_adv_nx;

  // Output stage: verdicts become visible one cycle after the decision edge
  logic               r_o_pv, r_o_adv, r_o_blq;
  logic [1:0]         r_o_int;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pin      <= '0;
      r_entry    <= '0;
      r_cnt      <= '0;
      r_intentos <= '0;
      r_pv       <= 1'b0;
      r_adv      <= 1'b0;
      r_o_pv     <= 1'b0;
      r_o_adv    <= 1'b0;
      r_o_blq    <= 1'b0;
      r_o_int    <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_pin      <= w_pin_nx;
      r_entry    <= w_entry_nx;
      r_cnt      <= w_cnt_nx;
      r_intentos <= w_intentos_nx;
      r_pv       <= w_pv_nx;
      r_adv      <= w_adv_nx;
      r_o_pv     <= r_pv;
      r_o_adv    <= r_adv;
      r_o_blq    <= (r_state == BLOQUEADO);
      r_o_int    <= r_intentos;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_pin_nx      = r_pin;
    w_entry_nx    = r_entry;
    w_cnt_nx      = r_cnt;
    w_intentos_nx = r_intentos;
    w_pv_nx       = 1'b0;
    w_adv_nx      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.tarjeta_recibida) begin
          w_pin_nx      = bus.pin_correcto;
          w_cnt_nx      = '0;
          w_intentos_nx = '0;
          w_state_nx    = RECIBIENDO;
        end
      end

      RECIBIENDO: begin
        // Card removal wins over a digit arriving in the same cycle
        if (!bus.tarjeta_recibida) begin
          w_cnt_nx   = '0;
          w_state_nx = IDLE;
        end else if (bus.digito_stb && (bus.digito <= 4'd9)) begin
          w_entry_nx = PIN_W'({r_entry, bus.digito});
          w_cnt_nx   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N_DIGITOS - 1)) begin
            w_state_nx = COMPARA;
          end
        end
      end

      COMPARA: begin
        w_cnt_nx = '0;
        if (r_entry == r_pin) begin
          w_pv_nx    = 1'b1;
          w_state_nx = IDLE;
        end else if ((32'(r_intentos) + 32'd1) < 32'(MAX_INTENTOS)) begin
          w_intentos_nx = r_intentos + 2'(1);
          w_adv_nx      = 1'b1;
          w_state_nx    = RECIBIENDO;
        end else begin
          w_intentos_nx = 2'(MAX_INTENTOS);
          w_state_nx    = BLOQUEADO;
        end
      end

      BLOQUEADO: begin
        w_state_nx = BLOQUEADO;
      end

      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign bus.pin_valido  = r_o_pv;
  assign bus.advertencia = r_o_adv;
  assign bus.bloqueo     = r_o_blq;
  assign bus.intentos    = r_o_int;

endmodule
